// File: rtl/scramble_sequencer.sv
// Arbitrates the grid's line-select/fire inputs between the player and an
// LFSR-driven scramble engine that issues NUM_MOVES random line fires per start.

module scramble_sequencer #(
    parameter int unsigned NUM_MOVES = 16,
    parameter int unsigned FIRE_GAP  = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       user_fire_i,
    input  logic       user_nrow_i,
    input  logic [3:0] user_sel_i,
    input  logic       user_error_i,
    output logic       out_fire_o,
    output logic       out_nrow_o,
    output logic [3:0] out_sel_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] moves_left_o
);

    // An all-zero seed would lock the LFSR, so it falls back to the default.
    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [7:0]  MOVES    = 8'(NUM_MOVES);
    localparam logic [7:0]  GAP_LAST = 8'(FIRE_GAP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, FIRE, GAP, DONE} state_t;

    state_t      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [7:0]  count_q;
    logic [7:0]  gapCount_q;
    logic        fire_q;
    logic        nrow_q;
    logic [3:0]  sel_q;
    logic        busy_q;
    logic        done_q;
    logic [3:0]  scramSel;

    // Fibonacci LFSR with taps 16,14,13,11, shifting right.
    always_comb begin
        lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        scramSel = 4'b0001 << lfsr_q[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            count_q    <= 8'd0;
            gapCount_q <= 8'd0;
            fire_q     <= 1'b0;
            nrow_q     <= 1'b0;
            sel_q      <= 4'b0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            fire_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (MOVES == 8'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            sel_q   <= 4'b0000;
                        end else begin
                            state_q <= SETUP;
                            busy_q  <= 1'b1;
                            count_q <= MOVES;
                            nrow_q  <= lfsr_q[2];
                            sel_q   <= scramSel;
                        end
                    end else begin
                        sel_q  <= user_error_i ? 4'b0000 : user_sel_i;
                        nrow_q <= user_nrow_i;
                        fire_q <= user_fire_i & ~user_error_i;
                    end
                end
                SETUP: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        sel_q   <= 4'b0000;
                        count_q <= 8'd0;
                    end else begin
                        state_q <= FIRE;
                        fire_q  <= 1'b1;
                    end
                end
                // The strobe is already on the wire here, so abort only cuts what follows.
                FIRE: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        sel_q   <= 4'b0000;
                        count_q <= 8'd0;
                    end else begin
                        state_q    <= GAP;
                        count_q    <= count_q - 8'd1;
                        gapCount_q <= 8'd0;
                    end
                end
                GAP: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        sel_q   <= 4'b0000;
                        count_q <= 8'd0;
                    end else if (gapCount_q == GAP_LAST) begin
                        if (count_q != 8'd0) begin
                            state_q <= SETUP;
                            nrow_q  <= lfsr_q[2];
                            sel_q   <= scramSel;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            sel_q   <= 4'b0000;
                        end
                    end else begin
                        gapCount_q <= gapCount_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    sel_q   <= 4'b0000;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    sel_q   <= 4'b0000;
                    count_q <= 8'd0;
                end
            endcase
        end
    end

    assign out_fire_o   = fire_q;
    assign out_nrow_o   = nrow_q;
    assign out_sel_o    = sel_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign moves_left_o = count_q;

endmodule

// File: tb/tb_scramble_sequencer.sv
// Scoreboard bench for scramble_sequencer: the driver predicts every fire and done
// pulse from a cycle-level model; a negedge monitor pops and compares them.

module tb_scramble_sequencer;

    localparam int          N    = 16;
    localparam int          G    = 4;
    localparam int          P    = 2 + G;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int         cyc;
        logic       nrow;
        logic [3:0] sel;
        int         left;
        bit         scram;
    } fireExp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       userFire = 1'b0;
    logic       userNrow = 1'b0;
    logic [3:0] userSel = 4'b0000;
    logic       userError = 1'b0;

    logic       outFire, outNrow, busy, done;
    logic [3:0] outSel;
    logic [7:0] movesLeft;
    logic       fire0, nrow0, busy0, done0;
    logic [3:0] sel0;
    logic [7:0] moves0;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         freeAt = 0;
    int         scramFires = 0;
    logic [15:0] mLfsr;
    fireExp_t   fireQ[$];
    int         doneQ[$];
    logic [4:0] logQ[$];
    logic [4:0] firstLog[$];
    fireExp_t   mon;
    logic       prevNrow = 1'b0;
    logic [3:0] prevSel = 4'b0000;

    scramble_sequencer #(.NUM_MOVES(N), .FIRE_GAP(G), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start_i(start), .abort_i(abort),
        .user_fire_i(userFire), .user_nrow_i(userNrow), .user_sel_i(userSel),
        .user_error_i(userError), .out_fire_o(outFire), .out_nrow_o(outNrow),
        .out_sel_o(outSel), .busy_o(busy), .done_o(done), .moves_left_o(movesLeft)
    );

    scramble_sequencer #(.NUM_MOVES(0), .FIRE_GAP(G), .LFSR_SEED(SEED)) dutZero (
        .clk(clk), .reset(reset), .start_i(start), .abort_i(abort),
        .user_fire_i(userFire), .user_nrow_i(userNrow), .user_sel_i(userSel),
        .user_error_i(userError), .out_fire_o(fire0), .out_nrow_o(nrow0),
        .out_sel_o(sel0), .busy_o(busy0), .done_o(done0), .moves_left_o(moves0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        logic fb;
        // Tap position p (1..16) sits at bit 16-p of a right-shifting register.
        fb = v[16-16] ^ v[16-14] ^ v[16-13] ^ v[16-11];
        return {fb, v[15:1]};
    endfunction

    function automatic logic [15:0] lfsrAdvance(input logic [15:0] v, input int n);
        logic [15:0] r = v;
        for (int i = 0; i < n; i++) r = lfsrNext(r);
        return r;
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        mLfsr <= reset ? SEED : lfsrNext(mLfsr);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic startScramble(input int c);
        logic [15:0] v;
        fireExp_t    e;
        for (int k = 0; k < N; k++) begin
            v       = lfsrAdvance(mLfsr, k * P);
            e.cyc   = c + 2 + k * P;
            e.nrow  = v[2];
            e.sel   = 4'b0000;
            e.sel[v[1:0]] = 1'b1;
            e.left  = N - k;
            e.scram = 1'b1;
            fireQ.push_back(e);
        end
        doneQ.push_back(c + 1 + N * P);
        freeAt = c + 2 + N * P;
    endtask

    // Drives one cycle of inputs and records what the grid should see as a result.
    task automatic applyStimulus(input bit st, input bit ab, input bit uf, input bit un,
                                 input logic [3:0] us, input bit ue, input bit rs);
        int       c = cyc;
        fireExp_t e;
        start = st; abort = ab; userFire = uf; userNrow = un;
        userSel = us; userError = ue; reset = rs;
        if (rs) begin
            fireQ.delete();
            doneQ.delete();
            freeAt = c + 1;
        end else if (ab && c < freeAt) begin
            fireQ.delete();
            doneQ.delete();
            freeAt = c + 1;
        end else if (c >= freeAt) begin
            if (st) begin
                startScramble(c);
            end else if (uf && !ue) begin
                e.cyc = c + 1; e.nrow = un; e.sel = us; e.left = 0; e.scram = 1'b0;
                fireQ.push_back(e);
            end
        end
        tick();
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 4'b0000, 0, 0);
    endtask

    task automatic runScramble(input bit lockout, input int abortAt);
        int         c0 = cyc;
        int         dEnd = cyc + 1 + N * P;
        bit         aborted = 0;
        logic [3:0] rs;
        applyStimulus(1, 0, 1, 1, 4'b0010, 0, 0);
        while (cyc <= dEnd + 1) begin
            checkOutput("busy_window", busy, (cyc >= c0 + 1 && cyc <= c0 + N * P && !aborted));
            if (cyc == c0 + 1) begin
                checkOutput("moves_left_load", movesLeft, N);
                checkOutput("zero_moves_done", done0, 1);
                checkOutput("zero_moves_nofire", fire0, 0);
            end
            if (cyc == c0 + 2) checkOutput("zero_moves_done_once", done0, 0);
            if (aborted && cyc == c0 + abortAt + 1) begin
                checkOutput("abort_moves_left", movesLeft, 0);
                checkOutput("abort_sel", outSel, 0);
                checkOutput("abort_fire", outFire, 0);
            end
            if (abortAt >= 0 && cyc == c0 + abortAt) begin
                applyStimulus(0, 1, 0, 0, 4'b0000, 0, 0);
                aborted = 1;
            end else if (lockout && cyc <= c0 + N * P && (cyc - c0) % 3 == 0) begin
                rs = 4'b0001 << $urandom_range(0, 3);
                applyStimulus(1, 0, 1, 1'($urandom_range(0, 1)), rs, 0, 0);
            end else if (cyc == dEnd) begin
                applyStimulus(0, 0, 1, 1, 4'b1000, 0, 0);
            end else begin
                idle();
            end
        end
    endtask

    // Monitor: every fire/done the DUT shows must match the next predicted one.
    always @(negedge clk) begin
        if (outFire === 1'b1) begin
            if (fireQ.size() == 0) begin
                checkOutput("fire_expected", outFire, 0);
            end else begin
                mon = fireQ.pop_front();
                checkOutput("fire_cycle", cyc, mon.cyc);
                checkOutput("fire_sel", outSel, mon.sel);
                checkOutput("fire_nrow", outNrow, mon.nrow);
                if (mon.scram) begin
                    checkOutput("fire_moves_left", movesLeft, mon.left);
                    checkOutput("fire_sel_setup", prevSel, mon.sel);
                    checkOutput("fire_nrow_setup", prevNrow, mon.nrow);
                    scramFires++;
                    logQ.push_back({outNrow, outSel});
                end
            end
        end
        if (done === 1'b1) begin
            if (doneQ.size() == 0) begin
                checkOutput("done_expected", done, 0);
            end else begin
                checkOutput("done_cycle", cyc, doneQ.pop_front());
                checkOutput("done_moves_left", movesLeft, 0);
                checkOutput("done_sel", outSel, 0);
                checkOutput("done_busy", busy, 0);
            end
        end
        checkOutput("zero_moves_busy", busy0, 0);
        prevNrow <= outNrow;
        prevSel  <= outSel;
    end

    initial begin
        logic [3:0] us;
        bit         ue;
        bit         un;
        int         c0;

        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 4'b0000, 0, 1);
        checkOutput("reset_fire", outFire, 0);
        checkOutput("reset_nrow", outNrow, 0);
        checkOutput("reset_sel", outSel, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_moves_left", movesLeft, 0);
        idle();

        applyStimulus(0, 0, 1, 1, 4'b0100, 0, 0);
        checkOutput("pass_fire", outFire, 1);
        checkOutput("pass_sel", outSel, 4'b0100);
        checkOutput("pass_nrow", outNrow, 1);
        applyStimulus(0, 0, 0, 1, 4'b0100, 0, 0);
        checkOutput("pass_fire_single", outFire, 0);
        applyStimulus(0, 0, 1, 1, 4'b0100, 1, 0);
        checkOutput("pass_err_fire", outFire, 0);
        checkOutput("pass_err_sel", outSel, 0);

        for (int i = 0; i < 40; i++) begin
            us = 4'($urandom_range(0, 15));
            ue = ($countones(us) != 1);
            un = 1'($urandom_range(0, 1));
            applyStimulus(0, 0, 1'($urandom_range(0, 1)), un, us, ue, 0);
            checkOutput("rand_sel", outSel, ue ? 4'b0000 : us);
            checkOutput("rand_nrow", outNrow, un);
        end
        idle();

        scramFires = 0;
        runScramble(1, -1);
        checkOutput("lockout_fire_count", scramFires, N);
        for (int i = 0; i < 3; i++) idle();

        scramFires = 0;
        runScramble(0, 2 + 4 * P + 2);
        checkOutput("abort_fire_count", scramFires, 5);
        for (int i = 0; i < 3; i++) idle();

        c0 = cyc;
        applyStimulus(1, 0, 0, 0, 4'b0000, 0, 0);
        while (cyc < c0 + 2 + 2 * P) idle();
        applyStimulus(0, 0, 0, 0, 4'b0000, 0, 1);
        checkOutput("midreset_fire", outFire, 0);
        checkOutput("midreset_nrow", outNrow, 0);
        checkOutput("midreset_sel", outSel, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_done", done, 0);
        checkOutput("midreset_moves_left", movesLeft, 0);
        idle();
        checkOutput("midreset_no_refire", outFire, 0);

        for (int r = 0; r < 2; r++) begin
            applyStimulus(0, 0, 0, 0, 4'b0000, 0, 1);
            for (int i = 0; i < 5; i++) idle();
            logQ.delete();
            runScramble(0, -1);
            if (r == 0) firstLog = logQ;
        end
        checkOutput("determinism_len", logQ.size(), firstLog.size());
        for (int i = 0; i < firstLog.size() && i < logQ.size(); i++)
            checkOutput("determinism_seq", logQ[i], firstLog[i]);

        for (int i = 0; i < 3; i++) idle();
        checkOutput("pending_fires", fireQ.size(), 0);
        checkOutput("pending_done", doneQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
